seq_divider: RTL and testbench



---
 rtl/seq_divider_pkg.sv | 19 +
 rtl/seq_divider_step.sv | 30 +++
 rtl/seq_divider.sv | 111 +++++++++++
 tb/tb_seq_divider.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential signed divider: FSM encoding,
// default operand width and iteration-counter sizing.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    PREP = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int N_DEF = 5;

  // Counter must reach 2N-1 with headroom for the compare.
  function automatic int cnt_w(input int n);
    return $clog2(2 * n) + 1;
  endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One combinational restoring-division step on unsigned magnitudes.
// Latency: zero (pure combinational); backpressure: none.
module seq_divider_step
  import seq_divider_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N:0]     p,
  input  logic [2*N-1:0] qm,
  input  logic [N-1:0]   bm,
  output logic [N:0]     p_nxt,
  output logic [2*N-1:0] qm_nxt
);

  logic [N+1:0] sh;
  logic [N+1:0] trial;

  always_comb begin
    sh    = {p, qm[2*N-1]};
    trial = sh - {2'b00, bm};
    if (!trial[N+1]) begin
      p_nxt  = trial[N:0];
      qm_nxt = {qm[2*N-2:0], 1'b1};
    end else begin
      p_nxt  = sh[N:0];
      qm_nxt = {qm[2*N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Signed restoring divider, 2N-bit dividend by N-bit divisor; low rst loads operands.
// Latency 2N+2 clocks after rst release (1 on divide-by-zero); no backpressure, result held until reset.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2*N-1:0] a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] q,
  output logic [N-1:0]   r,
  output logic           done,
  output logic           dbz,
  output logic           ovf
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(2 * N - 1);

  div_state_t state, nxt;

  logic [2*N-1:0] a_r;
  logic [N-1:0]   b_r;
  logic [N:0]     p;
  logic [2*N-1:0] qm;
  logic [N-1:0]   bm;
  logic [CW-1:0]  cnt;
  logic           sign_q, sign_r;
  logic           ld, stp, fx;
  logic           b_zero;
  logic [N:0]     p_nxt;
  logic [2*N-1:0] qm_nxt;

  assign b_zero = (b_r == '0);

  always_ff @(posedge clk) begin
    if (!rst) state <= PREP;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      PREP:    nxt = b_zero ? DONE : DIV;
      DIV:     if (cnt == LAST) nxt = FIX;
      FIX:     nxt = DONE;
      DONE:    nxt = DONE;
      default: nxt = PREP;
    endcase
  end

  always_comb begin
    ld  = 1'b0;
    stp = 1'b0;
    fx  = 1'b0;
    case (state)
      PREP:    ld  = 1'b1;
      DIV:     stp = 1'b1;
      FIX:     fx  = 1'b1;
      default: ;
    endcase
  end

  seq_divider_step #(.N(N)) u_step (
    .p      (p),
    .qm     (qm),
    .bm     (bm),
    .p_nxt  (p_nxt),
    .qm_nxt (qm_nxt)
  );

  // Dividend magnitude is shifted out of qm while quotient bits shift in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_r  <= a;
      b_r  <= b;
      q    <= '0;
      r    <= '0;
      done <= 1'b0;
      dbz  <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (ld) begin
        qm     <= a_r[2*N-1] ? -a_r : a_r;
        bm     <= b_r[N-1] ? -b_r : b_r;
        sign_q <= a_r[2*N-1] ^ b_r[N-1];
        sign_r <= a_r[2*N-1];
        p      <= '0;
        cnt    <= '0;
        if (b_zero) begin
          dbz  <= 1'b1;
          done <= 1'b1;
        end
      end
      if (stp) begin
        p   <= p_nxt;
        qm  <= qm_nxt;
        cnt <= cnt + CW'(1);
      end
      if (fx) begin
        q    <= sign_q ? -qm : qm;
        r    <= sign_r ? -p[N-1:0] : p[N-1:0];
        ovf  <= (a_r == {1'b1, {(2*N-1){1'b0}}}) && (b_r == '1);
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed check of seq_divider against an integer-arithmetic model.
module tb_seq_divider;

  localparam int N = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [2*N-1:0] a   = '0;
  logic [N-1:0]   b   = '0;
  logic [2*N-1:0] q;
  logic [N-1:0]   r;
  logic           done, dbz, ovf;

  int n_cmp = 0;
  int n_bad = 0;

  seq_divider #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .q    (q),
    .r    (r),
    .done (done),
    .dbz  (dbz),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference: SV integer division truncates toward zero, % follows the dividend.
  function automatic void model(input logic [2*N-1:0] av, input logic [N-1:0] bv,
                                output logic [2*N-1:0] eq, output logic [N-1:0] er,
                                output logic edbz, output logic eovf, output int elat);
    int ai, bi, qi, ri;
    ai = $signed(av);
    bi = $signed(bv);
    if (bi == 0) begin
      eq = '0; er = '0; edbz = 1'b1; eovf = 1'b0; elat = 1;
    end else begin
      qi = ai / bi;
      ri = ai % bi;
      eq = qi[2*N-1:0];
      er = ri[N-1:0];
      edbz = 1'b0;
      eovf = (qi > (2 ** (2*N-1)) - 1);
      elat = 2 * N + 2;
    end
  endfunction

  task automatic load(input logic [2*N-1:0] av, input logic [N-1:0] bv, input bit check_clr);
    @(negedge clk);
    rst = 1'b0;
    a = av;
    b = bv;
    @(posedge clk);
    #1;
    if (check_clr) begin
      chk("clr_done", 32'(done), 32'd0);
      chk("clr_q", 32'(q), 32'd0);
      chk("clr_r", 32'(r), 32'd0);
      chk("clr_flags", 32'({dbz, ovf}), 32'd0);
    end
  endtask

  task automatic release_and_check(input logic [2*N-1:0] av, input logic [N-1:0] bv);
    logic [2*N-1:0] eq;
    logic [N-1:0]   er;
    logic           edbz, eovf;
    int             elat, k;
    model(av, bv, eq, er, edbz, eovf, elat);
    @(negedge clk);
    rst = 1'b1;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        k = i;
        break;
      end
    end
    if (k == 0) begin
      chk("timeout", 32'd0, 32'd1);
      return;
    end
    chk("latency", 32'(k), 32'(elat));
    chk("q", 32'(q), 32'(eq));
    chk("r", 32'(r), 32'(er));
    chk("dbz", 32'(dbz), 32'(edbz));
    chk("ovf", 32'(ovf), 32'(eovf));
    @(negedge clk);
    a = 10'($urandom);
    b = 5'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("hold", 32'({done, dbz, ovf, r, q}), 32'({1'b1, edbz, eovf, er, eq}));
  endtask

  task automatic run_op(input logic [2*N-1:0] av, input logic [N-1:0] bv);
    load(av, bv, 1'b1);
    release_and_check(av, bv);
  endtask

  initial begin
    logic [2*N-1:0] ra;
    logic [N-1:0]   rb;

    // Reset state with rst held low from time zero.
    @(posedge clk);
    #1;
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_flags", 32'({done, dbz, ovf}), 32'd0);

    run_op(-10'sd4, -5'sd2);
    run_op(10'd48, 5'd6);
    run_op(10'd47, -5'sd5);
    run_op(-10'sd47, 5'd5);
    run_op(10'd100, 5'd0);
    run_op(10'h200, 5'h1F);
    run_op(10'h200, 5'd1);
    run_op(10'h1FF, 5'h10);
    run_op(10'h200, 5'h10);

    // Abort a running divide with a new load.
    load(10'd48, 5'd6, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    load(10'd20, 5'd3, 1'b1);
    release_and_check(10'd20, 5'd3);

    for (int i = 0; i < 40; i++) begin
      ra = 10'($urandom);
      rb = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom);
      run_op(ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
